// File: rtl/cpu_t_port_receiver.sv
// Receiving end of the CPUSystem T output port: captures strobed bytes into a
// first-word-fall-through FIFO and keeps a running checksum and byte count.
module cpu_t_port_receiver #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [WIDTH-1:0]         T,
    input  logic                     TValid,
    input  logic                     OutReady,
    output logic [WIDTH-1:0]         OutData,
    output logic                     OutValid,
    output logic                     Full,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow,
    input  logic                     ClearOverflow,
    output logic [WIDTH-1:0]         Checksum,
    output logic [15:0]              ByteCount
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULLCOUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rp;
    logic [AW-1:0]    wp;
    logic             pop;
    logic             accept;
    logic             drop;

    // Flags come straight from the registered count so no handshake input
    // reaches them combinationally.
    assign OutValid = (Count != '0);
    assign Full     = (Count == FULLCOUNT);
    assign OutData  = mem[rp];

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop    = OutReady & OutValid;
    assign accept = TValid & (~Full | pop);
    assign drop   = TValid & Full & ~pop;

    always_ff @(posedge Clock) begin
        if (accept) begin
            mem[wp] <= T;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rp    <= '0;
            wp    <= '0;
            Count <= '0;
        end else begin
            if (accept) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            case ({accept, pop})
                2'b10:   Count <= Count + (AW+1)'(1);
                2'b01:   Count <= Count - (AW+1)'(1);
                default: Count <= Count;
            endcase
        end
    end

    // A drop in the same cycle as a clear request keeps the flag set.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Overflow <= 1'b0;
        end else if (drop) begin
            Overflow <= 1'b1;
        end else if (ClearOverflow) begin
            Overflow <= 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Checksum  <= '0;
            ByteCount <= '0;
        end else if (accept) begin
            Checksum <= Checksum + T;
            if (ByteCount != 16'hFFFF) begin
                ByteCount <= ByteCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_t_port_receiver.sv
// Directed self-checking bench for cpu_t_port_receiver: reset, FIFO order,
// full/overflow boundaries, pointer wrap and asynchronous reset.
module tb_cpu_t_port_receiver;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             Clock;
    logic             Reset;
    logic [WIDTH-1:0] T;
    logic             TValid;
    logic             OutReady;
    logic [WIDTH-1:0] OutData;
    logic             OutValid;
    logic             Full;
    logic [3:0]       Count;
    logic             Overflow;
    logic             ClearOverflow;
    logic [WIDTH-1:0] Checksum;
    logic [15:0]      ByteCount;

    int compared;
    int mismatched;

    cpu_t_port_receiver #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .T(T),
        .TValid(TValid),
        .OutReady(OutReady),
        .OutData(OutData),
        .OutValid(OutValid),
        .Full(Full),
        .Count(Count),
        .Overflow(Overflow),
        .ClearOverflow(ClearOverflow),
        .Checksum(Checksum),
        .ByteCount(ByteCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs; returns 1 time unit after the rising edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic c);
        TValid        = v;
        T             = d;
        OutReady      = r;
        ClearOverflow = c;
        @(posedge Clock);
        #1;
    endtask

    task automatic doReset();
        TValid = 1'b0; T = '0; OutReady = 1'b0; ClearOverflow = 1'b0;
        Reset = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin
        logic [7:0] exp2 [3];
        logic [7:0] q [$];
        logic [7:0] sum8;
        logic [7:0] data;
        logic       rdy;

        compared = 0;
        mismatched = 0;
        Reset = 1'b1;
        #3;

        // Reset then idle.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("rst OutValid", 32'(OutValid), 32'd0);
        checkOutput("rst Count", 32'(Count), 32'd0);
        checkOutput("rst Full", 32'(Full), 32'd0);
        checkOutput("rst Checksum", 32'(Checksum), 32'd0);
        checkOutput("rst ByteCount", 32'(ByteCount), 32'd0);
        checkOutput("rst Overflow", 32'(Overflow), 32'd0);

        // Three pushes, then three pops.
        exp2[0] = 8'h05; exp2[1] = 8'h0A; exp2[2] = 8'hFF;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, exp2[i], 1'b0, 1'b0);
        checkOutput("t2 Count", 32'(Count), 32'd3);
        checkOutput("t2 OutData", 32'(OutData), 32'h05);
        checkOutput("t2 Checksum", 32'(Checksum), 32'h0E);
        checkOutput("t2 ByteCount", 32'(ByteCount), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2 pop data", 32'(OutData), 32'(exp2[i]));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("t2 drained OutValid", 32'(OutValid), 32'd0);

        // Fill to full, overflow, clear, and set-beats-clear.
        doReset();
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        checkOutput("t3 Full", 32'(Full), 32'd1);
        checkOutput("t3 Count full", 32'(Count), 32'd8);
        applyStimulus(1'b1, 8'h09, 1'b0, 1'b0);
        checkOutput("t3 Overflow", 32'(Overflow), 32'd1);
        checkOutput("t3 ByteCount", 32'(ByteCount), 32'd8);
        checkOutput("t3 Checksum", 32'(Checksum), 32'h24);
        checkOutput("t3 Count after drop", 32'(Count), 32'd8);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t3 cleared", 32'(Overflow), 32'd0);
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
        checkOutput("t3 set wins", 32'(Overflow), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t3 cleared again", 32'(Overflow), 32'd0);

        // Full with simultaneous push and pop.
        checkOutput("t4 popped byte", 32'(OutData), 32'h01);
        applyStimulus(1'b1, 8'h09, 1'b1, 1'b0);
        checkOutput("t4 Count", 32'(Count), 32'd8);
        checkOutput("t4 Overflow", 32'(Overflow), 32'd0);
        checkOutput("t4 Full", 32'(Full), 32'd1);
        checkOutput("t4 ByteCount", 32'(ByteCount), 32'd9);
        checkOutput("t4 Checksum", 32'(Checksum), 32'h2D);
        for (int i = 0; i < 8; i++) begin
            checkOutput("t4 drain data", 32'(OutData), 32'(i + 2));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("t4 drained OutValid", 32'(OutValid), 32'd0);

        // Twenty pushes with interleaved pops so both pointers wrap twice.
        doReset();
        sum8 = 8'h00;
        for (int i = 0; i < 20; i++) begin
            data = 8'(8'h30 + i * 7);
            rdy  = (i % 3) != 0;
            checkOutput("t5 OutValid", 32'(OutValid), 32'(q.size() != 0));
            if (rdy && q.size() != 0) begin
                checkOutput("t5 order", 32'(OutData), 32'(q[0]));
                void'(q.pop_front());
            end
            q.push_back(data);
            sum8 = sum8 + data;
            applyStimulus(1'b1, data, rdy, 1'b0);
            checkOutput("t5 Count", 32'(Count), 32'(q.size()));
        end
        for (int k = 0; k < 12 && q.size() != 0; k++) begin
            checkOutput("t5 drain order", 32'(OutData), 32'(q[0]));
            void'(q.pop_front());
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("t5 model drained", 32'(q.size()), 32'd0);
        checkOutput("t5 drained OutValid", 32'(OutValid), 32'd0);
        checkOutput("t5 Checksum", 32'(Checksum), 32'(sum8));
        checkOutput("t5 ByteCount", 32'(ByteCount), 32'd20);

        // Asynchronous reset mid-cycle with five entries held.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        checkOutput("t6 Count before", 32'(Count), 32'd5);
        TValid = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("t6 async Count", 32'(Count), 32'd0);
        checkOutput("t6 async OutValid", 32'(OutValid), 32'd0);
        checkOutput("t6 async Full", 32'(Full), 32'd0);
        checkOutput("t6 async Checksum", 32'(Checksum), 32'd0);
        checkOutput("t6 async ByteCount", 32'(ByteCount), 32'd0);
        checkOutput("t6 async Overflow", 32'(Overflow), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        applyStimulus(1'b1, 8'h7E, 1'b1, 1'b0);
        checkOutput("t6 OutData", 32'(OutData), 32'h7E);
        checkOutput("t6 OutValid", 32'(OutValid), 32'd1);
        checkOutput("t6 Count no bypass", 32'(Count), 32'd1);
        checkOutput("t6 ByteCount", 32'(ByteCount), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
